// File: rtl/bp_resolve_pkg.sv
// Types shared by the resolve unit and its prediction queue.
package bp_resolve_pkg;
  `include "common.svh"

  typedef struct packed {
    addr_t pc;
    addr_t pre_pc;
    logic  taken;
  } pred_entry_t;

  typedef struct packed {
    addr_t pc;
    addr_t dest_pc;
    addr_t ret_pc;
    logic  is_branch;
    logic  is_j;
    logic  is_jal;
    logic  is_jalr;
    logic  is_jr_ra;
    logic  taken;
  } upd_t;

  typedef enum logic {
    RS_RUN      = 1'b0,
    RS_REDIRECT = 1'b1
  } rs_state_e;
endpackage

// File: rtl/bp_pred_fifo.sv
// Prediction queue: sync FIFO with flush; head visible combinationally, pop/push take effect next edge.
// Pushes while full and pops while empty are ignored; flush beats push at the same edge.
module bp_pred_fifo
  import bp_resolve_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_vld,
  input  pred_entry_t push_dat,
  input  logic        pop_vld,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output pred_entry_t head_dat
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  pred_entry_t    mem_q [DEPTH];
  pred_entry_t    mem_d [DEPTH];

  // Extra MSB tells a full ring (MSBs differ) from an empty one.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_dat = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_vld && !full) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = push_dat;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_vld && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/common.svh
// Address type shared by the branch-prediction blocks.
`ifndef COMMON_SVH
`define COMMON_SVH
localparam int ADDR_W = 32;
typedef logic [ADDR_W-1:0] addr_t;
`endif

// File: rtl/bp_resolve.sv
// Branch resolve: checks executed PCs against queued predictions; redirect and BPU update 1 cycle later.
// f_ready drops when the queue is full or a redirect is pending; redirect holds until redirect_ready.
module bp_resolve
  import bp_resolve_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             f_valid,
  input  addr_t            f_pc,
  input  addr_t            f_pre_pc,
  input  logic             f_hit,
  input  logic             f_taken,
  output logic             f_ready,
  input  logic             e_valid,
  input  addr_t            e_pc,
  input  addr_t            e_dest_pc,
  input  logic             e_is_branch,
  input  logic             e_is_j,
  input  logic             e_is_jal,
  input  logic             e_is_jalr,
  input  logic             e_is_jr_ra,
  input  logic             e_taken,
  output logic             redirect_valid,
  output addr_t            redirect_pc,
  input  logic             redirect_ready,
  output addr_t            upd_pc,
  output addr_t            upd_dest_pc,
  output addr_t            upd_ret_pc,
  output logic             upd_is_branch,
  output logic             upd_is_j,
  output logic             upd_is_jal,
  output logic             upd_is_jalr,
  output logic             upd_is_jr_ra,
  output logic             upd_taken,
  output logic [CNT_W-1:0] cnt_ctrl,
  output logic [CNT_W-1:0] cnt_miss
);
  rs_state_e        state_q, state_d;
  addr_t            redirect_pc_q, redirect_pc_d;
  upd_t             upd_q, upd_d;
  logic [CNT_W-1:0] cnt_ctrl_q, cnt_ctrl_d;
  logic [CNT_W-1:0] cnt_miss_q, cnt_miss_d;

  logic        fifo_full, fifo_empty;
  pred_entry_t head;
  logic        in_run, push, e_act, is_ctrl, head_hit, mispredict;
  addr_t       seq_pc, pred_pc, act_pc, fix_pc;

  assign in_run     = (state_q == RS_RUN);
  assign f_ready    = in_run && !fifo_full;
  assign push       = f_valid && f_hit && f_ready;
  assign e_act      = e_valid && in_run;
  assign is_ctrl    = e_is_branch || e_is_j || e_is_jal || e_is_jalr || e_is_jr_ra;
  assign head_hit   = e_act && !fifo_empty && (head.pc == e_pc);
  // Sequential successor skips the delay slot.
  assign seq_pc     = e_pc + addr_t'(8);
  assign pred_pc    = (head_hit && head.taken) ? head.pre_pc : seq_pc;
  assign act_pc     = (is_ctrl && e_taken) ? e_dest_pc : seq_pc;
  assign mispredict = e_act && (pred_pc != act_pc);
  // A taken prediction landing on a plain instruction resumes at the slot after it.
  assign fix_pc     = is_ctrl ? act_pc : e_pc + addr_t'(4);

  bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_vld (push && !mispredict),
    .push_dat ('{pc: f_pc, pre_pc: f_pre_pc, taken: f_taken}),
    .pop_vld  (head_hit),
    .flush    (mispredict),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head)
  );

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    upd_d         = '0;
    cnt_ctrl_d    = cnt_ctrl_q;
    cnt_miss_d    = cnt_miss_q;
    case (state_q)
      RS_RUN: begin
        if (mispredict) begin
          state_d       = RS_REDIRECT;
          redirect_pc_d = fix_pc;
          cnt_miss_d    = cnt_miss_q + CNT_W'(1);
        end
        if (e_act && is_ctrl) begin
          cnt_ctrl_d      = cnt_ctrl_q + CNT_W'(1);
          upd_d.pc        = e_pc;
          upd_d.dest_pc   = e_dest_pc;
          upd_d.ret_pc    = seq_pc;
          upd_d.is_branch = e_is_branch;
          upd_d.is_j      = e_is_j;
          upd_d.is_jal    = e_is_jal;
          upd_d.is_jalr   = e_is_jalr;
          upd_d.is_jr_ra  = e_is_jr_ra;
          upd_d.taken     = e_taken;
        end
      end
      RS_REDIRECT: begin
        if (redirect_ready) state_d = RS_RUN;
      end
      default: state_d = RS_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= RS_RUN;
      redirect_pc_q <= '0;
      upd_q         <= '0;
      cnt_ctrl_q    <= '0;
      cnt_miss_q    <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      upd_q         <= upd_d;
      cnt_ctrl_q    <= cnt_ctrl_d;
      cnt_miss_q    <= cnt_miss_d;
    end
  end

  assign redirect_valid = (state_q == RS_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign upd_pc         = upd_q.pc;
  assign upd_dest_pc    = upd_q.dest_pc;
  assign upd_ret_pc     = upd_q.ret_pc;
  assign upd_is_branch  = upd_q.is_branch;
  assign upd_is_j       = upd_q.is_j;
  assign upd_is_jal     = upd_q.is_jal;
  assign upd_is_jalr    = upd_q.is_jalr;
  assign upd_is_jr_ra   = upd_q.is_jr_ra;
  assign upd_taken      = upd_q.taken;
  assign cnt_ctrl       = cnt_ctrl_q;
  assign cnt_miss       = cnt_miss_q;
endmodule

// File: tb/tb_bp_resolve.sv
// Bench for bp_resolve: directed scenarios plus random traffic against a queue-based reference model.
module tb_bp_resolve;
  import bp_resolve_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic f_valid, f_hit, f_taken, e_valid, redirect_ready;
  logic e_is_branch, e_is_j, e_is_jal, e_is_jalr, e_is_jr_ra, e_taken;
  addr_t f_pc, f_pre_pc, e_pc, e_dest_pc;
  logic f_ready, redirect_valid;
  addr_t redirect_pc, upd_pc, upd_dest_pc, upd_ret_pc;
  logic upd_is_branch, upd_is_j, upd_is_jal, upd_is_jalr, upd_is_jr_ra, upd_taken;
  logic [CNT_W-1:0] cnt_ctrl, cnt_miss;

  always #5 clk = ~clk;

  bp_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .f_valid(f_valid), .f_pc(f_pc), .f_pre_pc(f_pre_pc), .f_hit(f_hit), .f_taken(f_taken),
    .f_ready(f_ready),
    .e_valid(e_valid), .e_pc(e_pc), .e_dest_pc(e_dest_pc),
    .e_is_branch(e_is_branch), .e_is_j(e_is_j), .e_is_jal(e_is_jal), .e_is_jalr(e_is_jalr),
    .e_is_jr_ra(e_is_jr_ra), .e_taken(e_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .upd_pc(upd_pc), .upd_dest_pc(upd_dest_pc), .upd_ret_pc(upd_ret_pc),
    .upd_is_branch(upd_is_branch), .upd_is_j(upd_is_j), .upd_is_jal(upd_is_jal),
    .upd_is_jalr(upd_is_jalr), .upd_is_jr_ra(upd_is_jr_ra), .upd_taken(upd_taken),
    .cnt_ctrl(cnt_ctrl), .cnt_miss(cnt_miss)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: predictions as a plain queue, redirect as a flag.
  pred_entry_t mq[$];
  bit          m_redir;
  addr_t       m_rpc;
  int unsigned m_ctrl, m_miss;
  bit [5:0]    mu_kind;  // branch, j, jal, jalr, jr_ra, taken
  addr_t       mu_pc, mu_dest, mu_ret;

  task automatic model_reset();
    mq.delete();
    m_redir = 0; m_rpc = '0; m_ctrl = 0; m_miss = 0;
    mu_kind = '0; mu_pc = '0; mu_dest = '0; mu_ret = '0;
  endtask

  task automatic model_step();
    bit push, ctrl, matched, miss;
    addr_t seq, pred, act;
    pred_entry_t ent;
    mu_kind = '0; mu_pc = '0; mu_dest = '0; mu_ret = '0;
    if (m_redir) begin
      if (redirect_ready) m_redir = 0;
      return;
    end
    push = f_valid && f_hit && (mq.size() < DEPTH);
    if (e_valid) begin
      ctrl    = e_is_branch | e_is_j | e_is_jal | e_is_jalr | e_is_jr_ra;
      seq     = e_pc + 32'd8;
      matched = (mq.size() != 0) && (mq[0].pc == e_pc);
      pred    = (matched && mq[0].taken) ? mq[0].pre_pc : seq;
      act     = (ctrl && e_taken) ? e_dest_pc : seq;
      miss    = (pred != act);
      if (ctrl) begin
        m_ctrl++;
        mu_kind = {e_is_branch, e_is_j, e_is_jal, e_is_jalr, e_is_jr_ra, e_taken};
        mu_pc = e_pc; mu_dest = e_dest_pc; mu_ret = seq;
      end
      if (miss) begin
        m_miss++;
        m_redir = 1;
        m_rpc = (!ctrl && matched && mq[0].taken) ? e_pc + 32'd4 : act;
        mq.delete();
        push = 0;
      end else if (matched) begin
        void'(mq.pop_front());
      end
    end
    if (push) begin
      ent.pc = f_pc; ent.pre_pc = f_pre_pc; ent.taken = f_taken;
      mq.push_back(ent);
    end
  endtask

  task automatic check_all();
    chk("f_ready", f_ready, !m_redir && (mq.size() < DEPTH));
    chk("redirect_valid", redirect_valid, m_redir);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("upd_pc", upd_pc, mu_pc);
    chk("upd_dest_pc", upd_dest_pc, mu_dest);
    chk("upd_ret_pc", upd_ret_pc, mu_ret);
    chk("upd_strobes", {upd_is_branch, upd_is_j, upd_is_jal, upd_is_jalr, upd_is_jr_ra, upd_taken}, mu_kind);
    chk("cnt_ctrl", cnt_ctrl, m_ctrl);
    chk("cnt_miss", cnt_miss, m_miss);
  endtask

  task automatic set_idle();
    f_valid = 0; f_hit = 0; f_taken = 0; f_pc = '0; f_pre_pc = '0;
    e_valid = 0; e_pc = '0; e_dest_pc = '0; e_taken = 0;
    e_is_branch = 0; e_is_j = 0; e_is_jal = 0; e_is_jalr = 0; e_is_jr_ra = 0;
    redirect_ready = 0;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge after checking.
  task automatic run_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_push(input addr_t pc, input addr_t pre, input bit tk);
    set_idle();
    f_valid = 1; f_hit = 1; f_pc = pc; f_pre_pc = pre; f_taken = tk;
    run_cycle();
  endtask

  task automatic do_exec(input addr_t pc, input addr_t dest, input bit [4:0] kind, input bit tk);
    set_idle();
    e_valid = 1; e_pc = pc; e_dest_pc = dest; e_taken = tk;
    {e_is_branch, e_is_j, e_is_jal, e_is_jalr, e_is_jr_ra} = kind;
    run_cycle();
  endtask

  task automatic do_idle(input bit rdy);
    set_idle();
    redirect_ready = rdy;
    run_cycle();
  endtask

  initial begin
    set_idle();
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    resetn = 1;

    // Correctly predicted taken branch.
    do_push(32'h1000, 32'h2000, 1);
    do_exec(32'h1000, 32'h2000, 5'b10000, 1);
    chk("b_ok_redirect", redirect_valid, 1'b0);
    chk("b_ok_upd_branch", upd_is_branch, 1'b1);
    do_idle(0);
    chk("b_ok_miss", cnt_miss, 0);

    // Predicted taken, resolved not taken.
    do_push(32'h1000, 32'h2000, 1);
    do_exec(32'h1000, 32'h2000, 5'b10000, 0);
    chk("b_nt_rpc", redirect_pc, 32'h1008);
    f_valid = 1; f_hit = 1; f_pc = 32'h1100;
    run_cycle();
    chk("b_nt_hold", redirect_pc, 32'h1008);
    chk("b_nt_busy", f_ready, 1'b0);
    do_idle(1);
    chk("b_nt_miss", cnt_miss, 1);
    chk("b_nt_run", redirect_valid, 1'b0);

    // Unpredicted jal.
    do_exec(32'h3000, 32'h4000, 5'b00100, 1);
    chk("jal_rpc", redirect_pc, 32'h4000);
    chk("jal_ret", upd_ret_pc, 32'h3008);
    do_idle(1);

    // Fill to DEPTH, overflow push, then one pop.
    for (int i = 0; i < DEPTH; i++) do_push(32'h6000 + 32'(i * 4), 32'h9000, 0);
    chk("full_ready", f_ready, 1'b0);
    do_push(32'h6010, 32'h9000, 0);
    do_exec(32'h6000, 32'h0, 5'b00000, 0);
    chk("pop_ready", f_ready, 1'b1);
    for (int i = 1; i <= DEPTH; i++) do_exec(32'h6000 + 32'(i * 4), 32'h0, 5'b00000, 0);
    chk("drain_miss", cnt_miss, 2);

    // Taken prediction aliasing a plain instruction.
    do_push(32'h5000, 32'h7000, 1);
    do_exec(32'h5000, 32'h0, 5'b00000, 0);
    chk("alias_rpc", redirect_pc, 32'h5004);
    chk("alias_upd", {upd_pc, upd_is_branch, upd_is_j, upd_is_jal, upd_taken}, '0);
    do_idle(1);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      int k;
      set_idle();
      f_valid = ($urandom_range(0, 9) < 7);
      f_hit = ($urandom_range(0, 9) < 8);
      f_pc = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      f_pre_pc = $urandom_range(0, 1) ? f_pc + 32'd8 : 32'h8000 + 32'($urandom_range(0, 3) * 8);
      f_taken = $urandom_range(0, 1);
      e_valid = $urandom_range(0, 1);
      e_pc = ((mq.size() != 0) && $urandom_range(0, 3) != 0) ? mq[0].pc
                                                                : 32'h1000 + 32'($urandom_range(0, 7) * 4);
      e_dest_pc = ((mq.size() != 0) && $urandom_range(0, 1)) ? mq[0].pre_pc
                                                               : 32'h8000 + 32'($urandom_range(0, 3) * 8);
      e_taken = $urandom_range(0, 1);
      k = $urandom_range(0, 6);
      e_is_branch = (k == 0); e_is_j = (k == 1); e_is_jal = (k == 2);
      e_is_jalr = (k == 3); e_is_jr_ra = (k == 4);
      redirect_ready = $urandom_range(0, 1);
      run_cycle();
    end

    // Reset while a redirect is pending.
    while (m_redir) do_idle(1);
    do_exec(32'h3000, 32'h4000, 5'b00100, 1);
    chk("rst_pre_redir", redirect_valid, 1'b1);
    resetn = 0;
    #1;
    model_reset();
    chk("rst_redir_drop", redirect_valid, 1'b0);
    check_all();
    @(negedge clk);
    resetn = 1;
    do_push(32'h1000, 32'h2000, 1);
    do_exec(32'h1000, 32'h2000, 5'b10000, 1);
    do_idle(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
